// File: rtl/toffoli_pkg.sv
// Shared constants and helpers for the Toffoli-based round-robin mux.
// Ancilla values are the constant inputs that turn a Toffoli gate into AND or NOT.
package toffoli_pkg;

  localparam logic ANC0       = 1'b0;
  localparam logic ANC1       = 1'b1;
  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Ceiling log2, used to size channel indices and to locate tree levels.
  function automatic int toffoli_lgn(input int n);
    int r;
    r = 32'sd0;
    while ((32'sd1 <<< r) < n) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/toffoli_gate.sv
// Reversible Toffoli (CCNOT) primitive: controls pass through, target flips when both controls are 1.
module toffoli_gate (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_p,
  output logic o_q,
  output logic o_r
);

  assign o_p = i_a;
  assign o_q = i_b;
  assign o_r = i_c ^ (i_a & i_b);

endmodule

// File: rtl/toffoli_mux2_w.sv
// W-bit 2:1 mux whose every bit is y = (s & d1) | (!s & d0) built purely from Toffoli cells.
// OR is formed as NOT(AND(NOT a, NOT b)); all pass-through control copies are garbage.
module toffoli_mux2_w
  import toffoli_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  output logic [W-1:0] o_y
);

  for (genvar b = 0; b < W; b++) begin : g_bit
    logic        w_sel_n;
    logic        w_t1;
    logic        w_t0;
    logic        w_t1_n;
    logic        w_t0_n;
    logic        w_nor;
    logic [13:0] w_unused_garb;

    toffoli_gate u_not_s (.i_a(ANC1),    .i_b(ANC1),     .i_c(i_sel),
                          .o_p(w_unused_garb[0]),  .o_q(w_unused_garb[1]),  .o_r(w_sel_n));
    toffoli_gate u_and_1 (.i_a(i_sel),   .i_b(i_d1[b]),  .i_c(ANC0),
                          .o_p(w_unused_garb[2]),  .o_q(w_unused_garb[3]),  .o_r(w_t1));
    toffoli_gate u_and_0 (.i_a(w_sel_n), .i_b(i_d0[b]),  .i_c(ANC0),
                          .o_p(w_unused_garb[4]),  .o_q(w_unused_garb[5]),  .o_r(w_t0));
    toffoli_gate u_not_1 (.i_a(ANC1),    .i_b(ANC1),     .i_c(w_t1),
                          .o_p(w_unused_garb[6]),  .o_q(w_unused_garb[7]),  .o_r(w_t1_n));
    toffoli_gate u_not_0 (.i_a(ANC1),    .i_b(ANC1),     .i_c(w_t0),
                          .o_p(w_unused_garb[8]),  .o_q(w_unused_garb[9]),  .o_r(w_t0_n));
    toffoli_gate u_and_n (.i_a(w_t1_n),  .i_b(w_t0_n),   .i_c(ANC0),
                          .o_p(w_unused_garb[10]), .o_q(w_unused_garb[11]), .o_r(w_nor));
    toffoli_gate u_not_y (.i_a(ANC1),    .i_b(ANC1),     .i_c(w_nor),
                          .o_p(w_unused_garb[12]), .o_q(w_unused_garb[13]), .o_r(o_y[b]));
  end

endmodule

// File: rtl/toffoli_rr_mux.sv
// N-channel arbitrated mux (round-robin or fixed priority) with a registered valid/ready output.
// Data selection runs through a binary tree of Toffoli mux cells steered by the grant index.
module toffoli_rr_mux
  import toffoli_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = 8,
  parameter int LGN = toffoli_lgn(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic [N-1:0]     in_valid,
  input  logic [N*W-1:0]   in_data,
  output logic [N-1:0]     in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  output logic [LGN-1:0]   out_chan,
  input  logic             out_ready
);

  logic           r_out_valid;
  logic [W-1:0]   r_out_data;
  logic [LGN-1:0] r_out_chan;
  logic [LGN-1:0] r_ptr;

  logic           w_load;
  logic           w_grant_vld;
  logic [LGN-1:0] w_grant_idx;
  logic [LGN-1:0] w_cand;
  logic [N-1:0]   w_in_ready;
  logic [W-1:0]   w_node [1:2*N-1];

  assign w_load = !r_out_valid | out_ready;

  // Grant search; scanning from the far end lets the nearest requester overwrite earlier hits.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = {LGN{1'b0}};
    w_cand      = {LGN{1'b0}};
    if (mode == MODE_FIXED) begin
      for (int i = N - 1; i >= 0; i--) begin
        w_grant_vld = in_valid[i] ? 1'b1 : w_grant_vld;
        w_grant_idx = in_valid[i] ? LGN'(i) : w_grant_idx;
      end
    end else begin
      for (int k = N; k >= 1; k--) begin
        w_cand      = r_ptr + LGN'(k);
        w_grant_vld = in_valid[w_cand] ? 1'b1 : w_grant_vld;
        w_grant_idx = in_valid[w_cand] ? w_cand : w_grant_idx;
      end
    end
  end

  // One-hot accept strobe toward the granted channel only.
  always_comb begin
    w_in_ready = {N{1'b0}};
    if (!rst && w_load && w_grant_vld) begin
      w_in_ready[w_grant_idx] = 1'b1;
    end else begin
      w_in_ready = {N{1'b0}};
    end
  end

  // Heap-ordered tree: leaves N..2N-1 are channels, node k muxes children 2k and 2k+1.
  for (genvar i = 0; i < N; i++) begin : g_leaf
    assign w_node[N+i] = in_data[i*W +: W];
  end

  for (genvar k = 1; k < N; k++) begin : g_node
    localparam int D = toffoli_lgn(k + 1) - 1;
    toffoli_mux2_w #(.W(W)) u_mux (
      .i_sel (w_grant_idx[LGN-1-D]),
      .i_d0  (w_node[2*k]),
      .i_d1  (w_node[2*k+1]),
      .o_y   (w_node[k])
    );
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {W{1'b0}};
      r_out_chan  <= {LGN{1'b0}};
      r_ptr       <= {LGN{1'b1}};
    end else if (w_load) begin
      if (w_grant_vld) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_node[1];
        r_out_chan  <= w_grant_idx;
        if (mode == MODE_RR) begin
          r_ptr <= w_grant_idx;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;

endmodule

// File: doc/toffoli_rr_mux.md
Name: toffoli_rr_mux

Overview:
- Parametrised successor to the single-bit 2:1 Toffoli mux.
- Selects one of N channels of W-bit data and registers the result behind a valid/ready handshake.
- Arbitration is round-robin or fixed-priority.
- The data-select tree is built only from Toffoli-derived AND/OR/NOT cells, keeping the reversible-logic datapath style. Only the control and output registers are conventional flops.

Parameters:
N, 4, number of input channels; power of two, N >= 2
W, 8, data width per channel
LGN, $clog2(N), channel index width (derived; do not override)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
in_valid  input  N  per-channel valid
in_data  input  N*W  channel i occupies bits [i*W +: W]
in_ready  output  N  one-hot (or zero) accept strobe per channel
out_valid  output  1  output register holds a word
out_data  output  W  registered selected data
out_chan  output  LGN  index of channel that supplied out_data
out_ready  input  1  downstream accepts when high with out_valid

Behaviour:
- Reset:
  - Single clock domain `clk`. Reset is synchronous and active-high on `rst`.
  - While rst=1 at a rising edge: out_valid=0, out_data=0, out_chan=0, ptr=N-1 (so channel 0 is first in RR order).
  - in_ready is forced to 0 while rst is high.
- Load enable: `load = !out_valid | out_ready`. in_ready and load are combinational from out_valid and out_ready. There is no skid buffer.
- Grant (combinational):
  - mode=0: the first i with in_valid[i]=1, scanning ptr+1, ptr+2, … modulo N (wrap-around).
  - mode=1: the lowest i with in_valid[i]=1.
  - No valid input: no grant.
- in_ready[g] = load & grant_exists for the granted index g only. All other bits are 0.
- Transfer on a rising edge when load=1 and a grant exists: out_data <= in_data[g]; out_chan <= g; out_valid <= 1.
  - ptr <= g, in RR mode only. ptr holds in fixed mode.
- Drain: load=1 with no grant gives out_valid <= 0. out_data and out_chan hold their stale values.
- Hold: out_valid=1 and out_ready=0. The output register, ptr and all in_ready bits hold (in_ready=0).
- Latency is 1 cycle, input accept to out_valid. Full throughput is one word per cycle when out_ready is held at 1.
- Simultaneous events:
  - Downstream accept and new load in the same cycle is a normal back-to-back transfer.
  - Mode changes take effect at the next grant evaluation. ptr is retained across mode changes.
  - Reset mid-hold discards the held word.
- Source rule: in_data[i] must stay stable while in_valid[i]=1 and in_ready[i]=0. Violations are not detected.
- Datapath:
  - A log2(N)-level tree of W-bit 2:1 reversible mux cells, with select bits = grant index bits (LSB at leaf level).
  - Each bit cell realises y = (s & d1) | (!s & d0) using Toffoli AND (target tied 0), Toffoli NOT (controls tied 1) and a Toffoli-based OR.
  - Garbage outputs are left unconnected.
- Grant logic and ptr are ordinary RTL.

Decomposition:
- Shared package `toffoli_pkg`:
  - ancilla constants ANC0=1'b0 and ANC1=1'b1;
  - a function computing LGN;
  - the mode encoding constants MODE_RR=0 and MODE_FIXED=1.
- Sub-module `toffoli_mux2_w`:
  - a W-bit 2:1 mux built from per-bit Toffoli AND/NOT/OR cells;
  - instantiated N-1 times by a generate block to form the tree.
- The existing Toffoli gate primitive is reused unchanged inside `toffoli_mux2_w`.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all in_valid=0 -> out_valid=0, out_data=0, in_ready=0000 every cycle.
- RR fairness: N=4, mode=0, all in_valid=1, data[i]=8'h10+i, out_ready=1 -> out_chan sequence 0,1,2,3,0 and out_data 10,11,12,13,10, one per cycle starting 1 cycle after reset release.
- Fixed priority: mode=1, in_valid=1010, out_ready=1 -> out_chan=1 every cycle; in_ready=0010 every cycle; channel 3 is never served.
- Backpressure: RR running, out_ready=0 for 3 cycles while out_valid=1 -> out_data and out_chan are frozen, in_ready=0000, ptr unchanged. On out_ready=1, the next channel in RR order follows.
- RR wrap and sparse valid: ptr=3 (last grant ch3), in_valid=0100 -> grant ch2, in_ready=0100, out_chan=2. Then in_valid=0000 with out_ready=1 -> out_valid drops to 0 next cycle.
- Reset mid-hold: out_valid=1, out_ready=0, assert rst one cycle -> out_valid=0 after that edge. The first post-reset grant with all in_valid=1 is channel 0.
